// File: rtl/game_pkg.sv
// Shared constants for the register write arbiter slice.
// Contents:
//   DEF_N / DEF_W / DEF_AW  - default requester count, data width, address width
//   ST_IDLE / ST_GRANT / ST_RELEASE - arbiter state encoding
//   idx_width()             - width of an index into N requesters (min 1 bit)
package game_pkg;

  localparam int DEF_N  = 4;
  localparam int DEF_W  = 8;
  localparam int DEF_AW = 4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  // Index width for n entries; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Bus between requesters and the register write arbiter.
// Signals:
//   req      - per-requester level write request, held until granted
//   req_addr - packed addresses, requester i at [i*AW +: AW]
//   req_data - packed data, requester i at [i*W +: W]
//   gnt      - one-hot grant pulse
//   wr_en    - register bank write enable
//   wr_addr  - register bank write address
//   wr_data  - register bank write data
//   busy     - arbiter is not idle
// Modports: master (requester side), slave (arbiter side).
interface reg_write_arbiter_if
  import game_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int W  = DEF_W,
  parameter int AW = DEF_AW
);

  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [N*W-1:0]  req_data;
  logic [N-1:0]    gnt;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [W-1:0]    wr_data;
  logic            busy;

  modport master (
    output req, req_addr, req_data,
    input  gnt, wr_en, wr_addr, wr_data, busy
  );

  modport slave (
    input  req, req_addr, req_data,
    output gnt, wr_en, wr_addr, wr_data, busy
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational winner selection: scans req starting at ptr_i, wrapping
// from N-1 to 0, and returns the first active requester.
// Ports:
//   req_i    - request vector
//   ptr_i    - index where the scan starts (0 gives lowest-index priority)
//   valid_o  - some request is active
//   idx_o    - winner index
//   onehot_o - winner as a one-hot vector
module rr_pick
  import game_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int PW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic          valid_o,
  output logic [PW-1:0] idx_o,
  output logic [N-1:0]  onehot_o
);

  int cand;

  // First active request at or after ptr_i, modulo N.
  always_comb begin
    valid_o  = 1'b0;
    idx_o    = '0;
    onehot_o = '0;
    cand     = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr_i) + k) % N;
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = PW'(cand);
      end else begin
        valid_o = valid_o;
      end
    end
    if (valid_o) begin
      onehot_o[idx_o] = 1'b1;
    end else begin
      onehot_o = '0;
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates N level-held write requests onto one shared register bank port.
// A transfer walks IDLE -> GRANT -> RELEASE; GRANT drives a one-cycle gnt/wr_en
// pulse, RELEASE waits for the winner to drop its request so a held request
// is never written twice.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous active-low reset
//   bus   - reg_write_arbiter_if slave modport (req/addr/data in, gnt/wr_* /busy out)
// Build option: define ARB_ROUND_ROBIN_EN for round-robin selection starting
// after the last winner; otherwise fixed priority, lowest index wins.
module reg_write_arbiter
  import game_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int W  = DEF_W,
  parameter int AW = DEF_AW
) (
  input logic                clk,
  input logic                reset,
  reg_write_arbiter_if.slave bus
);

  localparam int PW = idx_width(N);

  logic [1:0]    state_q,   state_d;
  logic [PW-1:0] winner_q,  winner_d;
  logic [N-1:0]  gnt_q,     gnt_d;
  logic          wr_en_q,   wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [W-1:0]  wr_data_q, wr_data_d;

  logic          pick_valid;
  logic [PW-1:0] pick_idx;
  logic [N-1:0]  pick_onehot;
  logic [PW-1:0] pick_ptr;

`ifdef ARB_ROUND_ROBIN_EN
  logic [PW-1:0] ptr_q, ptr_d;
  assign pick_ptr = ptr_q;
`else
  assign pick_ptr = '0;
`endif

  rr_pick #(.N(N), .PW(PW)) u_pick (
    .req_i    (bus.req),
    .ptr_i    (pick_ptr),
    .valid_o  (pick_valid),
    .idx_o    (pick_idx),
    .onehot_o (pick_onehot)
  );

  // Next-state logic; grant outputs are computed here so they are registered.
  always_comb begin
    state_d   = state_q;
    winner_d  = winner_q;
    gnt_d     = '0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef ARB_ROUND_ROBIN_EN
    ptr_d     = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d   = ST_GRANT;
          winner_d  = pick_idx;
          gnt_d     = pick_onehot;
          wr_en_d   = 1'b1;
          wr_addr_d = bus.req_addr[int'(pick_idx)*AW +: AW];
          wr_data_d = bus.req_data[int'(pick_idx)*W +: W];
`ifdef ARB_ROUND_ROBIN_EN
          ptr_d     = (int'(pick_idx) == N-1) ? '0 : pick_idx + 1'b1;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        // Only the winner's request matters here; others wait in IDLE.
        if (!bus.req[winner_q]) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RELEASE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      winner_q  <= '0;
      gnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      winner_q  <= winner_d;
      gnt_q     <= gnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios followed by
// randomized request traffic, all checked against a transaction-level model.
module tb_reg_write_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_write_arbiter_if #(.N(N), .W(W), .AW(AW)) bus ();

  reg_write_arbiter #(.N(N), .W(W), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: one transaction in flight at a time.
  bit            m_active;  // a transfer has been accepted and not yet released
  bit            m_fresh;   // the cycle right after acceptance (write pulse)
  int            m_win;
  int            m_start;   // where the next search begins
  logic [AW-1:0] m_addr;
  logic [W-1:0]  m_data;

  int  raises [N];
  int  grants [N];
  bit  got    [N];
  int  order  [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int choose(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      if (r[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic model_edge();
    int w;
    if (!m_active) begin
      if (bus.req != '0) begin
        w        = choose(bus.req, m_start);
        m_active = 1'b1;
        m_fresh  = 1'b1;
        m_win    = w;
        m_addr   = bus.req_addr[w*AW +: AW];
        m_data   = bus.req_data[w*W +: W];
`ifdef ARB_ROUND_ROBIN_EN
        m_start  = (w + 1) % N;
`endif
      end
    end else if (m_fresh) begin
      m_fresh = 1'b0;
    end else if (!bus.req[m_win]) begin
      m_active = 1'b0;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [31:0] exp_gnt;
    exp_gnt = m_fresh ? (32'd1 << m_win) : 32'd0;
    chk({tag, "_gnt"},   32'(bus.gnt),     exp_gnt);
    chk({tag, "_wr_en"}, 32'(bus.wr_en),   32'(m_fresh));
    chk({tag, "_addr"},  32'(bus.wr_addr), 32'(m_addr));
    chk({tag, "_data"},  32'(bus.wr_data), 32'(m_data));
    chk({tag, "_busy"},  32'(bus.busy),    32'(m_active));
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_outputs(tag);
    for (int i = 0; i < N; i++) begin
      if (bus.gnt[i]) grants[i]++;
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    #1;
    reset   = 1'b0;
    bus.req = '0;
    #1;
    m_active = 1'b0;
    m_fresh  = 1'b0;
    m_win    = 0;
    m_start  = 0;
    m_addr   = '0;
    m_data   = '0;
    check_outputs("reset");
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic int gnt_index(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) begin
      if (g[i]) return i;
    end
    return -1;
  endfunction

  initial begin
    int cnt;
    bit draining;
    reset        = 1'b1;
    bus.req      = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    do_reset();
    step("idle");
    step("idle");

    // Single requester 2, addr 5, data 0xA3.
    bus.req_addr[2*AW +: AW] = 4'd5;
    bus.req_data[2*W +: W]   = 8'hA3;
    bus.req = 4'b0100;
    step("single");
    chk("single_gnt_const",  32'(bus.gnt),     32'h4);
    chk("single_wren_const", 32'(bus.wr_en),   32'h1);
    chk("single_addr_const", 32'(bus.wr_addr), 32'h5);
    chk("single_data_const", 32'(bus.wr_data), 32'hA3);
    step("single_hold");
    step("single_hold");
    chk("single_busy_hold", 32'(bus.busy), 32'h1);
    bus.req[2] = 1'b0;
    step("single_drop");
    chk("single_busy_drop", 32'(bus.busy), 32'h0);

    // Requester 1 held for five cycles after its grant: one write only.
    bus.req_addr[1*AW +: AW] = 4'd9;
    bus.req_data[1*W +: W]   = 8'h3C;
    bus.req = 4'b0010;
    step("held_grant");
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      step("held");
      cnt += int'(bus.wr_en);
    end
    chk("held_no_second_write", 32'(cnt), 32'd0);
    bus.req[1] = 1'b0;
    step("held_drop");
    bus.req[1] = 1'b1;
    step("held_rerise");
    chk("held_rerise_wren", 32'(bus.wr_en), 32'h1);
    chk("held_rerise_gnt",  32'(bus.gnt),   32'h2);
    bus.req[1] = 1'b0;
    step("held_end");
    step("held_end");

    // Reset asserted while in GRANT.
    bus.req_addr[0*AW +: AW] = 4'd7;
    bus.req_data[0*W +: W]   = 8'h11;
    bus.req = 4'b0001;
    step("pre_reset");
    chk("pre_reset_wren", 32'(bus.wr_en), 32'h1);
    do_reset();
    step("post_reset");
    chk("post_reset_busy", 32'(bus.busy), 32'h0);

    // All four request together; each drops on its grant.
    for (int i = 0; i < N; i++) begin
      bus.req_addr[i*AW +: AW] = AW'(i + 3);
      bus.req_data[i*W +: W]   = W'($urandom);
    end
    bus.req = 4'b1111;
    order.delete();
    for (int c = 0; c < 40 && order.size() < N; c++) begin
      step("all4");
      if (bus.gnt != '0) begin
        order.push_back(gnt_index(bus.gnt));
        bus.req[gnt_index(bus.gnt)] = 1'b0;
      end
    end
    chk("all4_count", 32'(order.size()), 32'd4);
    for (int k = 0; k < order.size(); k++) begin
      chk("all4_order", 32'(order[k]), 32'(k));
    end
    step("all4_tail");
    step("all4_tail");

    // Last winner 3, then 3 and 0 request together: 0 wins.
    bus.req = 4'b1000;
    step("wrap_g3");
    chk("wrap_g3_gnt", 32'(bus.gnt), 32'h8);
    bus.req[3] = 1'b0;
    step("wrap_rel");
    step("wrap_idle");
    bus.req = 4'b1001;
    step("wrap_pick");
    chk("wrap_pick_gnt", 32'(bus.gnt), 32'h1);
    bus.req[0] = 1'b0;
    step("wrap_rel2");
    step("wrap_idle2");
    step("wrap_pick3");
    chk("wrap_pick3_gnt", 32'(bus.gnt), 32'h8);
    bus.req[3] = 1'b0;
    step("wrap_end");
    step("wrap_end");

    // Random traffic, then drain; every raised request is served exactly once.
    for (int i = 0; i < N; i++) begin
      raises[i] = 0;
      grants[i] = 0;
      got[i]    = 1'b0;
    end
    draining = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (c == 400) draining = 1'b1;
      if (draining && bus.req == '0 && !m_active) break;
      for (int i = 0; i < N; i++) begin
        if (!bus.req[i]) begin
          bus.req_addr[i*AW +: AW] = AW'($urandom);
          bus.req_data[i*W +: W]   = W'($urandom);
          if (!draining && !(m_active && m_win == i) && $urandom_range(2) == 0) begin
            bus.req[i] = 1'b1;
            raises[i]++;
            got[i] = 1'b0;
          end
        end else if (got[i] && $urandom_range(1) == 0) begin
          bus.req[i] = 1'b0;
          got[i]     = 1'b0;
        end
      end
      step("rand");
      for (int i = 0; i < N; i++) begin
        if (bus.gnt[i]) got[i] = 1'b1;
      end
    end
    chk("drain_req_empty", 32'(bus.req),  32'h0);
    chk("drain_idle",      32'(bus.busy), 32'h0);
    for (int i = 0; i < N; i++) begin
      chk("served_once", 32'(grants[i]), 32'(raises[i]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, meaning number of requesters.
REQ-002 SHALL have parameter W, default 8, meaning register data width.
REQ-003 SHALL have parameter AW, default 4, meaning register-bank address width.
REQ-004 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req  input  N  per-requester write request, level, held until granted.
REQ-007 SHALL have port req_addr  input  N*AW  packed addresses, requester i at bits [i*AW +: AW].
REQ-008 SHALL have port req_data  input  N*W  packed data, requester i at bits [i*W +: W].
REQ-009 SHALL have port gnt  output  N  one-hot grant pulse, registered.
REQ-010 SHALL have port wr_en  output  1  write-enable to the shared register bank's enabled flip-flops.
REQ-011 SHALL have port wr_addr  output  AW  write address, registered.
REQ-012 SHALL have port wr_data  output  W  write data, registered.
REQ-013 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, GRANT and RELEASE.
REQ-015 SHALL, in IDLE with req nonzero at a clock edge, select one winner, capture its addr/data and move to GRANT.
REQ-016 SHALL, in GRANT, assert gnt[winner] and wr_en for exactly one cycle, with wr_addr/wr_data holding the captured values; latency from req sampled to wr_en is 1 cycle.
REQ-017 SHALL move GRANT -> RELEASE unconditionally.
REQ-018 SHALL remain in RELEASE while req[winner]=1 and return to IDLE on the first edge where it samples req[winner]=0, so a held request is never granted twice.
REQ-019 SHALL ignore req changes of non-winners outside IDLE; pending requests are served later, with no loss.
REQ-020 SHALL keep gnt all-zero and wr_en=0 in IDLE and RELEASE; wr_addr/wr_data hold their last values.
REQ-021 SHALL sustain at most one transfer per 3 cycles (IDLE, GRANT, RELEASE).
REQ-022 SHALL ignore addr/data of requesters whose req is 0.

Reset
REQ-023 SHALL, on reset=0 at any time including mid-GRANT, force state IDLE, gnt=0, wr_en=0, wr_addr=0, wr_data=0, busy=0 and the rotation pointer to 0, without waiting for a clock edge.
REQ-024 SHALL, after reset deasserts, evaluate req from the first rising edge onward.

Configuration
REQ-025 SHALL, with macro ARB_ROUND_ROBIN_EN defined, select the first active req at or above index (last winner + 1) mod N, wrapping from N-1 to 0.
REQ-026 SHALL, without ARB_ROUND_ROBIN_EN, use fixed priority with the lowest index winning and no pointer register.

Structure
REQ-027 SHALL take the state encoding enum and default parameter constants from shared package game_pkg.
REQ-028 SHALL place winner selection (req, pointer -> one-hot winner) in a combinational sub-module rr_pick.

Verification
REQ-029 SHALL cover: single req[2]=1 with addr=5, data=0xA3 -> next cycle gnt=4'b0100, wr_en=1, wr_addr=5, wr_data=0xA3, then busy until req[2] drops.
REQ-030 SHALL cover: req=4'b1111 held, each requester dropping its req on its grant, with ARB_ROUND_ROBIN_EN -> grants in order 0,1,2,3; without it -> order 0,1,2,3 by priority, each requester still granted once.
REQ-031 SHALL cover: req[1] held 5 cycles after its grant -> no second wr_en until req[1] falls and rises again.
REQ-032 SHALL cover: reset=0 asserted during GRANT -> wr_en and gnt go 0 immediately; IDLE and busy=0 after release.
REQ-033 SHALL cover: req[3]=1 with ARB_ROUND_ROBIN_EN and last winner 3 -> pointer wraps and requester 0 beats 3 when req=4'b1001.
